// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter and its display scanner.
// Holds the FSM encoding, the saturation value, the segment patterns and the double-dabble adjust step.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [9:0]  MAX_VAL   = 10'd999;
    localparam logic [11:0] BCD_SAT   = 12'h999;
    localparam logic [3:0]  LAST_ITER = 4'd9;

    // Segment order {a,b,c,d,e,f,g}, active high.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [11:0] dabble_adj(input logic [11:0] work);
        logic [11:0] adj;
        adj = work;
        for (int i = 0; i < 3; i++) begin
            if (work[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = work[i*4 +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Seven-segment decoder for one BCD digit; non-decimal codes blank the digit.
// Latency: purely combinational. Backpressure: none.
// Output order {a,b,c,d,e,f,g}.
module seg7_dec
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bin2bcd_scan.sv
// Double-dabble binary-to-BCD converter driving a 3-digit multiplexed 7-segment display.
// Latency: load accepted at edge N -> done/bcd valid after edge N+11; display scans continuously.
// Backpressure: load is dropped while busy; no queueing.
module bin2bcd_scan
    import bcd_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  cnt_in,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic        err,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam logic [15:0] PRE_LAST = 16'(SCAN_DIV - 1);

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_shift;
    logic        w_last;

    logic [9:0]  r_bin;
    logic [11:0] r_work;
    logic [3:0]  r_iter;
    logic        r_ovf;
    logic [11:0] r_bcd;
    logic        r_err;
    logic        r_done;
    logic [11:0] w_adj;

    logic [15:0] r_pre;
    logic [1:0]  r_dig;
    logic [2:0]  r_an;
    logic [6:0]  r_seg;
    logic        w_wrap;
    logic [3:0]  w_nib;
    logic [2:0]  w_an_sel;
    logic [6:0]  w_seg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_shift  = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_accept = 1'b1;
                    w_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (r_iter == LAST_ITER) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_last = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_adj = dabble_adj(r_work);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bin  <= '0;
            r_work <= '0;
            r_iter <= '0;
            r_ovf  <= 1'b0;
            r_bcd  <= '0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_bin  <= cnt_in;
                r_work <= '0;
                r_iter <= '0;
                r_ovf  <= (cnt_in > MAX_VAL);
            end else if (w_shift) begin
                // A carry out of the hundreds digit can only come from an input above 999.
                r_work <= {w_adj[10:0], r_bin[9]};
                r_bin  <= {r_bin[8:0], 1'b0};
                r_iter <= r_iter + 4'd1;
                r_ovf  <= r_ovf | w_adj[11];
            end
            if (w_last) begin
                r_bcd <= r_ovf ? BCD_SAT : r_work;
                r_err <= r_ovf;
            end
        end
    end

    assign w_wrap = (r_pre == PRE_LAST);

    always_comb begin
        w_nib    = r_bcd[11:8];
        w_an_sel = 3'b100;
        case (r_dig)
            2'd0: begin
                w_nib    = r_bcd[3:0];
                w_an_sel = 3'b001;
            end
            2'd1: begin
                w_nib    = r_bcd[7:4];
                w_an_sel = 3'b010;
            end
            default: begin
                w_nib    = r_bcd[11:8];
                w_an_sel = 3'b100;
            end
        endcase
    end

    seg7_dec u_seg7_dec (
        .i_digit (w_nib),
        .o_seg   (w_seg)
    );

    // an and seg are both registered from the same index so they always switch together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pre <= '0;
            r_dig <= '0;
            r_an  <= 3'b001;
            r_seg <= SEG_0;
        end else begin
            r_pre <= w_wrap ? 16'd0 : r_pre + 16'd1;
            if (w_wrap) begin
                r_dig <= (r_dig == 2'd2) ? 2'd0 : r_dig + 2'd1;
            end
            r_an  <= w_an_sel;
            r_seg <= w_seg;
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign bcd  = r_bcd;
    assign err  = r_err;
    assign seg  = r_seg;
    assign an   = r_an;

endmodule

// File: tb/tb_bin2bcd_scan.sv
// Self-checking bench for bin2bcd_scan against an arithmetic decimal-digit and segment-table model.
module tb_bin2bcd_scan;

    logic        clk;
    logic        rst;
    logic [9:0]  cnt_in;
    logic        load;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic        err;
    logic [6:0]  seg;
    logic [2:0]  an;

    int          vectors;
    int          miscompares;
    logic [11:0] exp_bcd;
    logic        exp_err;

    bin2bcd_scan #(.SCAN_DIV(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .cnt_in (cnt_in),
        .load   (load),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd),
        .err    (err),
        .seg    (seg),
        .an     (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        int h;
        int t;
        int u;
        if (v > 999) return 12'h999;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        return {h[3:0], t[3:0], u[3:0]};
    endfunction

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [3:0] digit_for(input logic [2:0] sel, input logic [11:0] b);
        case (sel)
            3'b001:  return b[3:0];
            3'b010:  return b[7:4];
            default: return b[11:8];
        endcase
    endfunction

    // Full conversion with fixed-latency checks; optional random load noise while busy.
    task automatic do_conv(input int v, input bit noisy, input string tag);
        logic [11:0] new_bcd;
        logic        new_err;
        new_bcd = ref_bcd(v);
        new_err = (v > 999);
        cnt_in  = 10'(v);
        load    = 1'b1;
        tick();
        for (int k = 0; k < 11; k++) begin
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0 || bcd !== exp_bcd || err !== exp_err) begin
                miscompares++;
                $display("FAIL %s busy-phase cycle %0d: busy=%b done=%b bcd=%h err=%b, want busy=1 done=0 bcd=%h err=%b",
                         tag, k, busy, done, bcd, err, exp_bcd, exp_err);
            end
            load   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            cnt_in = noisy ? 10'($urandom_range(0, 1023)) : cnt_in;
            tick();
        end
        load = 1'b0;
        exp_bcd = new_bcd;
        exp_err = new_err;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || bcd !== exp_bcd || err !== exp_err) begin
            miscompares++;
            $display("FAIL %s result(v=%0d): done=%b busy=%b bcd=%h err=%b, want done=1 busy=0 bcd=%h err=%b",
                     tag, v, done, busy, bcd, err, exp_bcd, exp_err);
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done width: done=%b, want 0", tag, done);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        load   = 1'b1;
        cnt_in = 10'd555;
        tick();
        tick();
        exp_bcd = 12'h000;
        exp_err = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bcd !== 12'h000 ||
            an !== 3'b001 || seg !== 7'b1111110) begin
            miscompares++;
            $display("FAIL reset: busy=%b done=%b err=%b bcd=%h an=%b seg=%b, want 0 0 0 000 001 1111110",
                     busy, done, err, bcd, an, seg);
        end
        load = 1'b0;
        rst  = 1'b1;
        tick();
    endtask

    task automatic test_max();
        do_conv(999, 1'b0, "max999");
    endtask

    task automatic test_endpoints();
        do_conv(0, 1'b0, "zero");
        do_conv(507, 1'b0, "v507");
        do_conv(1023, 1'b0, "sat1023");
        do_conv(42, 1'b0, "after_sat42");
    endtask

    task automatic test_load_while_busy();
        int dones;
        dones  = 0;
        cnt_in = 10'd123;
        load   = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        cnt_in = 10'd456;
        load   = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        exp_bcd = 12'h123;
        exp_err = 1'b0;
        vectors++;
        if (dones != 1 || bcd !== exp_bcd || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL load_while_busy: dones=%0d bcd=%h busy=%b, want dones=1 bcd=123 busy=0",
                     dones, bcd, busy);
        end
    endtask

    task automatic test_scan();
        logic [2:0] prev;
        int         run;
        do_conv(507, 1'b0, "scan_setup");
        prev = an;
        run  = 0;
        while (an === prev && run < 12) begin
            tick();
            run++;
        end
        vectors++;
        if (an === prev) begin
            miscompares++;
            $display("FAIL scan_start: an stuck at %b", an);
        end
        for (int s = 0; s < 4; s++) begin
            prev = an;
            run  = 0;
            do begin
                vectors++;
                if (seg !== ref_seg(digit_for(an, exp_bcd)) || !(an inside {3'b001, 3'b010, 3'b100})) begin
                    miscompares++;
                    $display("FAIL scan_seg: an=%b seg=%b, want seg=%b", an, seg,
                             ref_seg(digit_for(an, exp_bcd)));
                end
                tick();
                run++;
            end while (an === prev && run < 20);
            vectors++;
            if (run != 4 || an !== {prev[1:0], prev[2]}) begin
                miscompares++;
                $display("FAIL scan_dwell: an %b held %0d cycles then %b, want 4 cycles then %b",
                         prev, run, an, {prev[1:0], prev[2]});
            end
        end
    endtask

    task automatic test_mid_reset();
        int dones;
        dones  = 0;
        cnt_in = 10'd321;
        load   = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_pre: busy=%b, want 1", busy);
        end
        rst = 1'b0;
        tick();
        rst     = 1'b1;
        exp_bcd = 12'h000;
        exp_err = 1'b0;
        vectors++;
        if (busy !== 1'b0 || bcd !== 12'h000 || an !== 3'b001 || done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: busy=%b bcd=%h an=%b done=%b err=%b, want 0 000 001 0 0",
                     busy, bcd, an, done, err);
        end
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        vectors++;
        if (dones != 0 || bcd !== 12'h000) begin
            miscompares++;
            $display("FAIL mid_reset_nodone: dones=%0d bcd=%h, want 0 000", dones, bcd);
        end
    endtask

    task automatic test_back_to_back();
        int  wait_cnt;
        bit  stable;
        for (int v = 0; v < 1000; v++) begin
            cnt_in = 10'(v);
            load   = 1'b1;
            tick();
            load     = 1'b0;
            wait_cnt = 0;
            stable   = 1'b1;
            while (done !== 1'b1 && wait_cnt < 20) begin
                if (bcd !== exp_bcd) stable = 1'b0;
                tick();
                wait_cnt++;
            end
            vectors++;
            if (!stable) begin
                miscompares++;
                $display("FAIL sweep_hold v=%0d: bcd changed before done (prev %h)", v, exp_bcd);
            end
            exp_bcd = ref_bcd(v);
            vectors++;
            if (done !== 1'b1 || bcd !== exp_bcd || err !== 1'b0) begin
                miscompares++;
                $display("FAIL sweep v=%0d: done=%b bcd=%h err=%b after %0d cycles, want done=1 bcd=%h err=0",
                         v, done, bcd, err, wait_cnt, exp_bcd);
            end
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            do_conv(int'($urandom_range(0, 1023)), 1'b1, "random");
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        load        = 1'b0;
        cnt_in      = '0;
        exp_bcd     = '0;
        exp_err     = 1'b0;
        test_reset();
        test_max();
        test_endpoints();
        test_load_while_busy();
        test_scan();
        test_mid_reset();
        test_back_to_back();
        test_random();
        test_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
